mem_wb_stage: RTL
=================

// Module: mem_wb_stage
// PURPOSE
//  Memory stage plus MEM/WB pipeline register. Sits directly downstream of the EX/MEM register.
//  Consumes its mem* outputs and issues the data-cache request. Stalls the pipe until dhit.
//  Selects the writeback value and registers it for the WB stage. Holds the sticky halt.
// PARAMETERS
//  STALL_CNT_W  16  width of saturating memory-stall cycle counter
// PORTS
//  CLK             in   1   clock, all flops on posedge
//  nRST            in   1   async active-low reset
//  memcuDRE        in   1   load in MEM
//  memcuDWE        in   1   store in MEM
//  memcuHALT       in   1   halt in MEM
//  memMemToReg     in   1   writeback selects load data
//  memWEN          in   1   register-file write enable
//  memwsel         in   5   destination register
//  memOutput_Port  in   32  ALU result / data address
//  memrdat2        in   32  store data
//  meminstr        in   32  instruction word
//  memLUIflag      in   1   LUI writeback
//  memadv          in   1   EX/MEM loads a new instruction this edge (its exW)
//  dhit            in   1   cache completes request this cycle
//  dmemload        in   32  cache read data, valid with dhit
//  dmemREN         out  1   cache read request
//  dmemWEN         out  1   cache write request
//  dmemaddr        out  32  = memOutput_Port
//  dmemstore       out  32  = memrdat2
//  mem_stall       out  1   freeze IF..EX/MEM this cycle
//  wbWEN           out  1   registered write enable to WB
//  wbwsel          out  5   registered destination
//  wbwdat          out  32  registered writeback data
//  wbinstr         out  32  registered instruction (trace)
//  wbHALT          out  1   sticky halt
//  stall_cycles    out  STALL_CNT_W  saturating count of mem_stall cycles
// BEHAVIOUR
//  Reset (async): state=IDLE, ldbuf=0. wbWEN=0, wbwsel=0, wbwdat=0, wbinstr=0, wbHALT=0, stall_cycles=0.
//   Requests drop the same instant reset asserts, including mid-access.
//  mem op = (DRE|DWE) & ~wbHALT. DWE has priority: both high -> dmemWEN=1, dmemREN=0.
//  FSM states: IDLE (new instr), BUSY (request outstanding), DONE (retired, held by upstream).
//   Requests are combinational, asserted in IDLE/BUSY when op is a mem op. Never asserted in DONE.
//   The DONE rule means a held store is never reissued.
//  mem_stall = request asserted & ~dhit. Effective advance adv = memadv & ~mem_stall.
//  retire = state in {IDLE,BUSY} & ~mem_stall & ~wbHALT.
//  Transitions:
//   IDLE: mem op & ~dhit -> BUSY.
//   IDLE: retire & ~adv -> DONE.
//   IDLE: otherwise stay IDLE.
//   BUSY: dhit & adv -> IDLE.
//   BUSY: dhit & ~adv -> DONE.
//   BUSY: ~dhit -> stay BUSY.
//   DONE: adv -> IDLE; otherwise stay DONE.
//  ldbuf captures dmemload on every dhit with DRE.
//  Writeback data: MemToReg ? (dhit ? dmemload : ldbuf)
//   : LUIflag ? {meminstr[15:0],16'h0} : memOutput_Port.
//  WB register, every edge: on retire, load wbWEN=memWEN, wbwsel, wbwdat, wbinstr.
//   Otherwise wbWEN<=0 (bubble); other wb fields hold.
//   One retire per instruction, so a held instruction writes the register file exactly once.
//  Halt: retire with memcuHALT sets wbHALT=1, held until reset.
//   After halt: no requests, no retires, wbWEN=0, mem_stall=0.
//  Zero latency to cache. One cycle MEM->WB when dhit is same-cycle. Each miss cycle adds one.
//  stall_cycles += 1 each mem_stall cycle and saturates at all-ones.
//  Width rules: dmemaddr passes through with no alignment check. LUI shift is a fixed 16-bit concat.
// TESTING
//  1 ALU op: Output_Port=32'h1234, WEN=1, wsel=5, memadv=1
//    -> next edge wbWEN=1, wbwsel=5, wbwdat=32'h1234, mem_stall never high.
//  2 LW, dhit after 3 cycles with dmemload=32'hDEADBEEF
//    -> dmemREN high 3 cycles, mem_stall=1 for 2 of them, single wbWEN pulse,
//       wbwdat=32'hDEADBEEF, stall_cycles=2.
//  3 SW hit with memadv=0 for 4 cycles -> dmemWEN asserted exactly 1 cycle, state DONE,
//    no second request.
//  4 LUI meminstr[15:0]=16'hABCD, LUIflag=1 -> wbwdat=32'hABCD0000.
//  5 HALT retires, then LW follows -> wbHALT=1 sticky, no dmemREN, wbWEN=0 thereafter.
//  6 nRST low while BUSY -> dmemREN/dmemWEN=0 immediately, all wb outputs 0;
//    after release, state IDLE.

Source files
------------

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_stage
// Purpose  : Memory stage (data-cache request + stall) and MEM/WB register.
// Revision : 1.0
// ============================================================================
module mem_wb_stage #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   memcuDRE,
    input  logic                   memcuDWE,
    input  logic                   memcuHALT,
    input  logic                   memMemToReg,
    input  logic                   memWEN,
    input  logic [4:0]             memwsel,
    input  logic [31:0]            memOutput_Port,
    input  logic [31:0]            memrdat2,
    input  logic [31:0]            meminstr,
    input  logic                   memLUIflag,
    input  logic                   memadv,
    input  logic                   dhit,
    input  logic [31:0]            dmemload,
    output logic                   dmemREN,
    output logic                   dmemWEN,
    output logic [31:0]            dmemaddr,
    output logic [31:0]            dmemstore,
    output logic                   mem_stall,
    output logic                   wbWEN,
    output logic [4:0]             wbwsel,
    output logic [31:0]            wbwdat,
    output logic [31:0]            wbinstr,
    output logic                   wbHALT,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [31:0]              ldbuf_q;
    logic                     wbWEN_q;
    logic [4:0]               wbwsel_q;
    logic [31:0]              wbwdat_q, wdat_d;
    logic [31:0]              wbinstr_q;
    logic                     wbHALT_q;
    logic [STALL_CNT_W-1:0]   stall_q;

    logic mem_op, active, req, adv, retire;

    // Requests are gated by nRST so they drop the instant reset asserts.
    always_comb begin
        mem_op    = (memcuDRE | memcuDWE) & ~wbHALT_q;
        active    = (state_q != DONE);
        req       = active & mem_op & nRST;
        dmemWEN   = req & memcuDWE;
        dmemREN   = req & memcuDRE & ~memcuDWE;
        mem_stall = req & ~dhit;
        adv       = memadv & ~mem_stall;
        retire    = active & ~mem_stall & ~wbHALT_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (mem_op && !dhit)
                    state_d = BUSY;
                else if (retire && !adv)
                    state_d = DONE;
            end
            BUSY: begin
                if (dhit)
                    state_d = adv ? IDLE : DONE;
            end
            DONE: begin
                if (adv)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wdat_d = memOutput_Port;
        if (memMemToReg)
            wdat_d = dhit ? dmemload : ldbuf_q;
        else if (memLUIflag)
            wdat_d = {meminstr[15:0], 16'h0000};
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= IDLE;
            ldbuf_q   <= '0;
            wbWEN_q   <= 1'b0;
            wbwsel_q  <= '0;
            wbwdat_q  <= '0;
            wbinstr_q <= '0;
            wbHALT_q  <= 1'b0;
            stall_q   <= '0;
        end else begin
            state_q <= state_d;
            if (dhit && memcuDRE)
                ldbuf_q <= dmemload;
            // A held instruction retires once; later cycles are bubbles.
            if (retire) begin
                wbWEN_q   <= memWEN;
                wbwsel_q  <= memwsel;
                wbwdat_q  <= wdat_d;
                wbinstr_q <= meminstr;
                if (memcuHALT)
                    wbHALT_q <= 1'b1;
            end else begin
                wbWEN_q <= 1'b0;
            end
            if (mem_stall && (stall_q != '1))
                stall_q <= stall_q + STALL_CNT_W'(1);
        end
    end

    assign dmemaddr     = memOutput_Port;
    assign dmemstore    = memrdat2;
    assign wbWEN        = wbWEN_q;
    assign wbwsel       = wbwsel_q;
    assign wbwdat       = wbwdat_q;
    assign wbinstr      = wbinstr_q;
    assign wbHALT       = wbHALT_q;
    assign stall_cycles = stall_q;

endmodule
`default_nettype wire
